// File: rtl/icache_ro.sv
// rtl/icache_ro.sv - read-only direct-mapped instruction cache, 8 lines x 4 words
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   proc_read                fetch request from the IF stage
//   proc_write, proc_wdata   accepted but ignored (read-only cache)
//   proc_addr[29:0]          word address (pc[31:2])
//   proc_rdata[31:0]         word selected by proc_addr from the indexed line
//   proc_stall               high while the requested word is unavailable
//   mem_read                 line refill request (high for the whole REFILL state)
//   mem_write, mem_wdata     tied 0
//   mem_addr[27:0]           line address latched at the miss
//   mem_rdata[127:0]         refill line, word 0 in bits [31:0]
//   mem_ready                single-cycle pulse, mem_rdata valid that cycle
//   hit_count, miss_count    statistics counters
//
// Build option ICACHE_STATS_EN: when defined, hit_count counts IDLE read hits
// and miss_count counts REFILL entries; when undefined both are constant 0.

module icache_ro (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t       state;
    logic [7:0]   valid;
    logic [27:0]  line_addr;
    logic [127:0] data_mem [8];
    logic [24:0]  tag_mem  [8];

    logic [1:0]   offset;
    logic [2:0]   index;
    logic [24:0]  tag;
    logic [127:0] line_word;
    logic         hit;
    logic         refill_done;

    assign offset = proc_addr[1:0];
    assign index  = proc_addr[4:2];
    assign tag    = proc_addr[29:5];

    assign hit         = valid[index] && (tag_mem[index] == tag);
    assign refill_done = (state == REFILL) && mem_ready;

    // The indexed word is always presented, even when no fetch is requested.
    assign line_word  = data_mem[index];
    assign proc_rdata = line_word[{offset, 5'b00000} +: 32];

    assign proc_stall = (state == REFILL) || (proc_read && !hit);
    assign mem_read   = (state == REFILL);
    assign mem_addr   = line_addr;
    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;

    // Write port is part of the common cache interface but has no effect here.
    logic unused_write;
    assign unused_write = ^{proc_write, proc_wdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            line_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (proc_read && !hit) begin
                        line_addr <= proc_addr[29:2];
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        valid[line_addr[2:0]] <= 1'b1;
                        state                 <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tags carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            data_mem[line_addr[2:0]] <= mem_rdata;
            tag_mem[line_addr[2:0]]  <= line_addr[27:3];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE && proc_read) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_ro.sv
// tb/tb_icache_ro.sv - directed self-checking bench for icache_ro

module tb_icache_ro;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int n_cmp = 0;
    int n_bad = 0;

    icache_ro dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Stimulus only: present a line for one cycle while in REFILL, return at
    // the following negedge with the cache back in IDLE.
    task automatic refill(input logic [127:0] line);
        mem_ready = 1'b1;
        mem_rdata = line;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0;
        proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (mem_read !== 1'b0)    begin n_bad++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
        n_cmp++; if (proc_stall !== 1'b0)  begin n_bad++; $display("FAIL reset_stall got %b exp 0", proc_stall); end
        n_cmp++; if (mem_addr !== 28'h0)   begin n_bad++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        n_cmp++; if (mem_write !== 1'b0 || mem_wdata !== 128'h0) begin n_bad++; $display("FAIL reset_mem_write got %b/%h exp 0/0", mem_write, mem_wdata); end
        n_cmp++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_bad++; $display("FAIL reset_counters got %0d/%0d exp 0/0", hit_count, miss_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_miss;
        proc_read = 1'b1; proc_addr = 30'h0;
        #1;
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL miss_stall got %b exp 1", proc_stall); end
        n_cmp++; if (mem_read !== 1'b0)   begin n_bad++; $display("FAIL miss_idle_mem_read got %b exp 0", mem_read); end
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1)   begin n_bad++; $display("FAIL refill_mem_read got %b exp 1", mem_read); end
        n_cmp++; if (mem_addr !== 28'h0)  begin n_bad++; $display("FAIL refill_mem_addr got %h exp 0", mem_addr); end
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1 || proc_stall !== 1'b1) begin n_bad++; $display("FAIL refill_hold got %b/%b exp 1/1", mem_read, proc_stall); end
        refill({32'h4, 32'h3, 32'h2, 32'h1});
        n_cmp++; if (proc_stall !== 1'b0) begin n_bad++; $display("FAIL after_refill_stall got %b exp 0", proc_stall); end
        n_cmp++; if (proc_rdata !== 32'h1) begin n_bad++; $display("FAIL after_refill_rdata got %h exp 00000001", proc_rdata); end
        n_cmp++; if (mem_read !== 1'b0)   begin n_bad++; $display("FAIL after_refill_mem_read got %b exp 0", mem_read); end
    endtask

    task automatic test_hit;
        proc_addr = 30'h3;
        #1;
        n_cmp++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h4) begin n_bad++; $display("FAIL hit3 got %b/%h exp 0/00000004", proc_stall, proc_rdata); end
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b0)   begin n_bad++; $display("FAIL hit_no_mem_read got %b exp 0", mem_read); end
        proc_addr = 30'h1;
        #1;
        n_cmp++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h2) begin n_bad++; $display("FAIL hit1 got %b/%h exp 0/00000002", proc_stall, proc_rdata); end
        @(negedge clk);
    endtask

    task automatic test_replace;
        proc_addr = 30'h20;
        #1;
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL replace_stall got %b exp 1", proc_stall); end
        @(negedge clk);
        n_cmp++; if (mem_addr !== 28'h8 || mem_read !== 1'b1) begin n_bad++; $display("FAIL replace_mem_addr got %h/%b exp 0000008/1", mem_addr, mem_read); end
        refill({32'h14, 32'h13, 32'h12, 32'h11});
        n_cmp++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h11) begin n_bad++; $display("FAIL replace_rdata got %b/%h exp 0/00000011", proc_stall, proc_rdata); end
        proc_addr = 30'h0;
        #1;
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL evicted_miss got %b exp 1", proc_stall); end
        @(negedge clk);
        n_cmp++; if (mem_addr !== 28'h0) begin n_bad++; $display("FAIL evicted_mem_addr got %h exp 0", mem_addr); end
        refill({32'h4, 32'h3, 32'h2, 32'h1});
        n_cmp++; if (proc_rdata !== 32'h1) begin n_bad++; $display("FAIL restore_rdata got %h exp 00000001", proc_rdata); end
    endtask

    task automatic test_addr_change;
        proc_addr = 30'h40;
        @(negedge clk);
        proc_addr = 30'h44;
        #1;
        n_cmp++; if (mem_addr !== 28'h10) begin n_bad++; $display("FAIL latched_addr got %h exp 0000010", mem_addr); end
        refill({32'h34, 32'h33, 32'h32, 32'h31});
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL relookup_miss got %b exp 1", proc_stall); end
        @(negedge clk);
        n_cmp++; if (mem_addr !== 28'h11) begin n_bad++; $display("FAIL relookup_mem_addr got %h exp 0000011", mem_addr); end
        refill({32'h44, 32'h43, 32'h42, 32'h41});
        n_cmp++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h41) begin n_bad++; $display("FAIL relookup_rdata got %b/%h exp 0/00000041", proc_stall, proc_rdata); end
        proc_addr = 30'h42;
        #1;
        n_cmp++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h33) begin n_bad++; $display("FAIL first_line_kept got %b/%h exp 0/00000033", proc_stall, proc_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_refill;
        proc_addr = 30'h8;
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL pre_rst_mem_read got %b exp 1", mem_read); end
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL async_rst_mem_read got %b exp 0", mem_read); end
        n_cmp++; if (mem_addr !== 28'h0) begin n_bad++; $display("FAIL async_rst_mem_addr got %h exp 0", mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        proc_addr = 30'h3;
        #1;
        n_cmp++; if (proc_stall !== 1'b1) begin n_bad++; $display("FAIL post_rst_miss got %b exp 1", proc_stall); end
        proc_addr = 30'h8;
        @(negedge clk);
        n_cmp++; if (mem_addr !== 28'h2 || mem_read !== 1'b1) begin n_bad++; $display("FAIL post_rst_refill got %h/%b exp 0000002/1", mem_addr, mem_read); end
        refill({32'h24, 32'h23, 32'h22, 32'h21});
        n_cmp++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h21) begin n_bad++; $display("FAIL post_rst_rdata got %b/%h exp 0/00000021", proc_stall, proc_rdata); end
    endtask

    task automatic test_ignored_inputs;
        proc_read = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = {4{32'hBADC0DE5}};
        #1;
        n_cmp++; if (proc_stall !== 1'b0 || mem_read !== 1'b0) begin n_bad++; $display("FAIL idle_ready_stall got %b/%b exp 0/0", proc_stall, mem_read); end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
        n_cmp++; if (proc_rdata !== 32'h21 || mem_read !== 1'b0) begin n_bad++; $display("FAIL idle_ready_data got %h/%b exp 00000021/0", proc_rdata, mem_read); end
        proc_write = 1'b1; proc_wdata = 32'hDEADBEEF; proc_addr = 30'hA;
        @(negedge clk);
        proc_write = 1'b0; proc_wdata = '0; proc_read = 1'b1;
        #1;
        n_cmp++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h23) begin n_bad++; $display("FAIL write_ignored got %b/%h exp 0/00000023", proc_stall, proc_rdata); end
        @(negedge clk);
        proc_read = 1'b0;
    endtask

    task automatic test_stats;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        proc_read = 1'b1; proc_addr = 30'h0;
        @(negedge clk);
        refill({32'h4, 32'h3, 32'h2, 32'h1});
        proc_read = 1'b0;
        @(negedge clk);
        proc_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            proc_addr = 30'(i);
            @(negedge clk);
        end
        proc_read = 1'b0;
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL stats_miss got %0d exp 1", miss_count); end
        n_cmp++; if (hit_count !== 32'd3)  begin n_bad++; $display("FAIL stats_hit got %0d exp 3", hit_count); end
`else
        n_cmp++; if (miss_count !== 32'd0) begin n_bad++; $display("FAIL stats_miss got %0d exp 0", miss_count); end
        n_cmp++; if (hit_count !== 32'd0)  begin n_bad++; $display("FAIL stats_hit got %0d exp 0", hit_count); end
`endif
    endtask

    initial begin
        test_reset;
        test_first_miss;
        test_hit;
        test_replace;
        test_addr_change;
        test_reset_mid_refill;
        test_ignored_inputs;
        test_stats;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
